// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port: word/half/byte loads and
// stores on a word-organised array, with read-modify-write for sub-word stores.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmemreq,
  input  logic        dmemwe,
  input  logic [31:0] dmemaddr,
  input  logic [2:0]  dmemop,
  input  logic [31:0] dmemdatain,
  output logic        dmemready,
  output logic        dmemack,
  output logic        dmemerr,
  output logic [31:0] dmemdataout
);

  typedef enum logic [1:0] {IDLE, RD, FIN} state_t;

  state_t                  state;
  logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH+1:0]   addrQ;
  logic [2:0]              opQ;
  logic                    weQ;
  logic [31:0]             dataQ;
  logic [31:0]             rdata;

  logic                    accept;
  logic                    opIllegal;
  logic                    misaligned;
  logic                    outOfRange;
  logic                    reqErr;
  logic                    wordStore;
  logic [ADDR_WIDTH-1:0]   wordIdx;
  logic [ADDR_WIDTH-1:0]   wordIdxQ;
  logic [7:0]              byteVal;
  logic [15:0]             halfVal;
  logic [31:0]             loadResult;
  logic [31:0]             mergedWord;

  assign dmemready  = (state == IDLE) & reset;
  assign accept     = dmemreq & dmemready;
  // BU/HU only make sense for loads; a store with op[2] set is rejected.
  assign opIllegal  = (dmemop == 3'b011) | (dmemop == 3'b110) | (dmemop == 3'b111) |
                      (dmemwe & dmemop[2]);
  assign misaligned = ((dmemop[1:0] == 2'b01) & dmemaddr[0]) |
                      ((dmemop == 3'b010) & (dmemaddr[1:0] != 2'b00));
  assign outOfRange = |dmemaddr[31:ADDR_WIDTH+2];
  assign reqErr     = opIllegal | misaligned | outOfRange;
  assign wordStore  = dmemwe & (dmemop == 3'b010) & ~reqErr;
  assign wordIdx    = dmemaddr[ADDR_WIDTH+1:2];
  assign wordIdxQ   = addrQ[ADDR_WIDTH+1:2];

  always_comb begin
    byteVal    = rdata[{addrQ[1:0], 3'b000} +: 8];
    halfVal    = addrQ[1] ? rdata[31:16] : rdata[15:0];
    loadResult = rdata;
    case (opQ)
      3'b000:  loadResult = {{24{byteVal[7]}}, byteVal};
      3'b001:  loadResult = {{16{halfVal[15]}}, halfVal};
      3'b100:  loadResult = {24'h0, byteVal};
      3'b101:  loadResult = {16'h0, halfVal};
      default: loadResult = rdata;
    endcase
    mergedWord = rdata;
    if (opQ[1:0] == 2'b00)
      mergedWord[{addrQ[1:0], 3'b000} +: 8] = dataQ[7:0];
    else
      mergedWord[{addrQ[1], 4'b0000} +: 16] = dataQ[15:0];
  end

  // The array has no reset; FIN is left asynchronously on reset so a pending RMW is dropped.
  always_ff @(posedge clock) begin
    if (accept & wordStore)
      mem[wordIdx] <= dmemdatain;
    else if ((state == FIN) & weQ)
      mem[wordIdxQ] <= mergedWord;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dmemack     <= 1'b0;
      dmemerr     <= 1'b0;
      dmemdataout <= 32'h0;
      addrQ       <= '0;
      opQ         <= 3'b000;
      weQ         <= 1'b0;
      dataQ       <= 32'h0;
      rdata       <= 32'h0;
    end else begin
      dmemack <= 1'b0;
      dmemerr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (reqErr) begin
              dmemack     <= 1'b1;
              dmemerr     <= 1'b1;
              dmemdataout <= 32'h0;
            end else if (wordStore) begin
              dmemack <= 1'b1;
            end else begin
              addrQ <= dmemaddr[ADDR_WIDTH+1:0];
              opQ   <= dmemop;
              weQ   <= dmemwe;
              dataQ <= dmemdatain;
              state <= RD;
            end
          end
        end
        RD: begin
          rdata <= mem[wordIdxQ];
          state <= FIN;
        end
        FIN: begin
          dmemack <= 1'b1;
          if (!weQ)
            dmemdataout <= loadResult;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, lane extraction, RMW merges,
// error acknowledges, back-to-back word stores and reset during an RMW.
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic        dmemreq;
  logic        dmemwe;
  logic [31:0] dmemaddr;
  logic [2:0]  dmemop;
  logic [31:0] dmemdatain;
  logic        dmemready;
  logic        dmemack;
  logic        dmemerr;
  logic [31:0] dmemdataout;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                         OP_BU = 3'b100, OP_HU = 3'b101, OP_BAD = 3'b011;

  dmem_responder #(.ADDR_WIDTH(10)) dut (
    .clock(clock), .reset(reset), .dmemreq(dmemreq), .dmemwe(dmemwe),
    .dmemaddr(dmemaddr), .dmemop(dmemop), .dmemdatain(dmemdatain),
    .dmemready(dmemready), .dmemack(dmemack), .dmemerr(dmemerr),
    .dmemdataout(dmemdataout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues one request and waits for its ack; lat counts edges from accept to ack visible.
  task automatic applyStimulus(input logic we, input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] data, output int lat,
                               output logic [31:0] dout, output logic err);
    int w;
    dmemreq = 1'b1; dmemwe = we; dmemop = op; dmemaddr = addr; dmemdatain = data;
    w = 0;
    while (!dmemready && w < 8) begin
      @(posedge clock); #1; w++;
    end
    @(posedge clock); #1;
    dmemreq = 1'b0;
    lat = 1;
    while (!dmemack && lat < 8) begin
      @(posedge clock); #1; lat++;
    end
    dout = dmemdataout;
    err  = dmemerr;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (dmemready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", dmemready); end
    checks++; if (dmemack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b expected 0", dmemack); end
    checks++; if (dmemerr !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b expected 0", dmemerr); end
    checks++; if (dmemdataout !== 32'h0) begin errors++; $display("[TB] FAIL reset_dout got %h expected 00000000", dmemdataout); end
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checks++; if (dmemready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %b expected 1", dmemready); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] d; logic e;
    applyStimulus(1'b1, OP_W, 32'h10, 32'hDEADBEEF, lat, d, e);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL sw_latency got %0d expected 1", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL sw_err got %b expected 0", e); end
    applyStimulus(1'b0, OP_W, 32'h10, 32'h0, lat, d, e);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL lw_latency got %0d expected 3", lat); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_data got %h expected deadbeef", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL lw_err got %b expected 0", e); end
    applyStimulus(1'b1, OP_W, 32'h14, 32'h0, lat, d, e);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_keeps_dout got %h expected deadbeef", d); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] d; logic e;
    applyStimulus(1'b1, OP_B, 32'h13, 32'hFFFFFF80, lat, d, e);
    checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("[TB] FAIL sb_ack got lat=%0d err=%b expected lat=3 err=0", lat, e); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sb_keeps_dout got %h expected deadbeef", d); end
    applyStimulus(1'b0, OP_B, 32'h13, 32'h0, lat, d, e);
    checks++; if (d !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb got %h expected ffffff80", d); end
    applyStimulus(1'b0, OP_BU, 32'h13, 32'h0, lat, d, e);
    checks++; if (d !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu got %h expected 00000080", d); end
    applyStimulus(1'b0, OP_BU, 32'h11, 32'h0, lat, d, e);
    checks++; if (d !== 32'h000000BE) begin errors++; $display("[TB] FAIL lbu_lane1 got %h expected 000000be", d); end
    applyStimulus(1'b0, OP_W, 32'h10, 32'h0, lat, d, e);
    checks++; if (d !== 32'h80ADBEEF) begin errors++; $display("[TB] FAIL lw_after_sb got %h expected 80adbeef", d); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] d; logic e;
    applyStimulus(1'b1, OP_H, 32'h12, 32'hABCD1234, lat, d, e);
    checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("[TB] FAIL sh_ack got lat=%0d err=%b expected lat=3 err=0", lat, e); end
    applyStimulus(1'b0, OP_H, 32'h12, 32'h0, lat, d, e);
    checks++; if (d !== 32'h00001234) begin errors++; $display("[TB] FAIL lh_hi got %h expected 00001234", d); end
    applyStimulus(1'b0, OP_HU, 32'h10, 32'h0, lat, d, e);
    checks++; if (d !== 32'h0000BEEF) begin errors++; $display("[TB] FAIL lhu_lo got %h expected 0000beef", d); end
    applyStimulus(1'b0, OP_H, 32'h10, 32'h0, lat, d, e);
    checks++; if (d !== 32'hFFFFBEEF) begin errors++; $display("[TB] FAIL lh_lo got %h expected ffffbeef", d); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] d; logic e;
    logic        errWe   [5];
    logic [2:0]  errOp   [5];
    logic [31:0] errAddr [5];
    errWe = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    errOp = '{OP_H, OP_W, OP_BAD, OP_B, OP_BU};
    errAddr = '{32'h11, 32'h02, 32'h10, 32'h1000, 32'h00};
    applyStimulus(1'b1, OP_W, 32'h00, 32'h55AA55AA, lat, d, e);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(errWe[i], errOp[i], errAddr[i], 32'h99999999, lat, d, e);
      checks++;
      if (lat !== 1 || e !== 1'b1 || d !== 32'h0) begin
        errors++;
        $display("[TB] FAIL err_case%0d got lat=%0d err=%b dout=%h expected lat=1 err=1 dout=00000000", i, lat, e, d);
      end
    end
    applyStimulus(1'b0, OP_W, 32'h00, 32'h0, lat, d, e);
    checks++; if (d !== 32'h55AA55AA || e !== 1'b0) begin errors++; $display("[TB] FAIL err_word0_intact got %h err=%b expected 55aa55aa err=0", d, e); end
    applyStimulus(1'b0, OP_W, 32'h10, 32'h0, lat, d, e);
    checks++; if (d !== 32'h1234BEEF) begin errors++; $display("[TB] FAIL err_word4_intact got %h expected 1234beef", d); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e;
    dmemreq = 1'b1; dmemwe = 1'b1; dmemop = OP_W; dmemaddr = 32'h40; dmemdatain = 32'hA0000000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++;
      if (dmemready !== 1'b1 || dmemack !== 1'b1 || dmemerr !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d got ready=%b ack=%b err=%b expected 1 1 0", i, dmemready, dmemack, dmemerr);
      end
      if (i < 3) begin
        dmemaddr = 32'h40 + 32'(4 * (i + 1)); dmemdatain = 32'hA0000000 + 32'(i + 1);
      end else begin
        dmemreq = 1'b0;
      end
    end
    @(posedge clock); #1;
    checks++; if (dmemack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ack_drop got %b expected 0", dmemack); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, OP_W, 32'h40 + 32'(4 * i), 32'h0, lat, d, e);
      checks++;
      if (d !== 32'hA0000000 + 32'(i)) begin
        errors++;
        $display("[TB] FAIL b2b_read%0d got %h expected %h", i, d, 32'hA0000000 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_rmw();
    int lat; logic [31:0] d; logic e;
    applyStimulus(1'b1, OP_W, 32'h20, 32'h11223344, lat, d, e);
    dmemreq = 1'b1; dmemwe = 1'b1; dmemop = OP_B; dmemaddr = 32'h20; dmemdatain = 32'h000000AA;
    @(posedge clock); #1;
    dmemreq = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (dmemready !== 1'b0 || dmemack !== 1'b0 || dmemerr !== 1'b0 || dmemdataout !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_fin_outputs got ready=%b ack=%b err=%b dout=%h expected all zero",
               dmemready, dmemack, dmemerr, dmemdataout);
    end
    @(posedge clock); #1;
    checks++; if (dmemack !== 1'b0) begin errors++; $display("[TB] FAIL rst_fin_no_ack got %b expected 0", dmemack); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++; if (dmemack !== 1'b0) begin errors++; $display("[TB] FAIL rst_post_ack%0d got %b expected 0", i, dmemack); end
    end
    applyStimulus(1'b0, OP_W, 32'h20, 32'h0, lat, d, e);
    checks++; if (d !== 32'h11223344) begin errors++; $display("[TB] FAIL rst_rmw_dropped got %h expected 11223344", d); end
  endtask

  initial begin
    dmemreq = 1'b0; dmemwe = 1'b0; dmemaddr = 32'h0; dmemop = OP_W; dmemdatain = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_rmw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the memory-side end of the core's data-memory interface. Accepts load/store requests carrying the core's 3-bit memop encoding, performs word, halfword and byte accesses on a word-organised single-port array, and returns sign/zero-extended load data. Sub-word stores use read-modify-write. Misaligned, out-of-range and illegal-op requests complete with an error acknowledge. Sits between the core's load/store path and on-chip data RAM.

## Interface
- ADDR_WIDTH, 10, word-address width; array holds 2^ADDR_WIDTH 32-bit words.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- dmemreq  in  1  request valid.
- dmemwe  in  1  1 = store, 0 = load; sampled with dmemreq.
- dmemaddr  in  32  byte address.
- dmemop  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 illegal; BU/HU illegal for stores.
- dmemdatain  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- dmemready  out  1  request accepted on a rising edge where dmemreq & dmemready.
- dmemack  out  1  one-cycle completion pulse, exactly one per accepted request.
- dmemerr  out  1  qualifies dmemack: request failed, memory untouched.
- dmemdataout  out  32  load result, valid while dmemack & ~dmemwe-request.

## Operation
- States: IDLE, RD, FIN. dmemready = (state == IDLE) & reset high.
- Error check at acceptance: illegal op; H/HU with addr[0]=1; W with addr[1:0]≠0; dmemaddr[31:ADDR_WIDTH+2] ≠ 0. Error: no array access, stay IDLE, next cycle dmemack=1, dmemerr=1, dmemdataout=0.
- Word store (op 010, no error): array written at the accepting edge with dmemdatain; stay IDLE; dmemack=1 next cycle, dmemerr=0, dmemdataout unchanged.
- Load or sub-word store: capture addr/op/data/we at accept, go RD. RD: array word read, registered at next edge, go FIN. FIN: at next edge go IDLE and:
  - load: extract lane (byte lane = addr[1:0], lane 0 = bits 7:0; half = addr[1]), sign-extend for B/H, zero-extend for BU/HU, register into dmemdataout; dmemack=1.
  - sub-word store: merge dmemdatain[7:0] or [15:0] into selected lane, other lanes preserved, write merged word; dmemack=1; dmemdataout unchanged.
- dmemerr is 0 on every non-error ack.
- Array contents are not cleared by reset.

## Timing
- Reset low: state=IDLE, dmemready=0, dmemack=0, dmemerr=0, dmemdataout=0. In-flight request dropped without ack; a pending RMW write is not performed.
- Load/sub-word store: accept at edge E0, dmemack in cycle after E2; dmemready low during RD and FIN, high again from E2. Throughput one per 3 cycles.
- Word store and error: accept E0, dmemack in cycle after E0; dmemready stays high; back-to-back every cycle.
- Request in the cycle dmemack is high for a prior op is accepted normally; acks never merge or drop.
- Read-after-write: load accepted on the edge after a word store returns the stored data (write completes at accept edge before the RD read).
- dmemreq with dmemready low: ignored; requester must hold until accepted.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 -> acks after 1 and 3 cycles; dmemdataout=0xDEADBEEF, dmemerr=0.
- After above, SB 0x80 @0x13, LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
- SH 0x1234 @0x12, LH @0x12 -> 0x00001234; LHU @0x10 -> 0x0000BEEF; LH @0x10 -> 0xFFFFBEEF.
- LH @0x11, SW @0x02, dmemop=011, SB @0x00001000 (ADDR_WIDTH=10) -> each dmemack+dmemerr one cycle after accept, dmemdataout=0, array unchanged (verify via LW).
- Four SWs on consecutive cycles -> dmemready held high, four consecutive ack pulses, all words readable.
- SB 0xAA @0x20 (word 0x11223344) with reset low during FIN -> no ack, all outputs 0; after release LW @0x20 -> 0x11223344.
